score_tracker: RTL and testbench
================================

SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter TICK_RATE, default 10, timer increments per second; TICK_HIT = CLK_FREQ/TICK_RATE - 1.
REQ-003 SHALL provide parameter WIDTH, default 16, timer and table entry width in bits.
REQ-004 SHALL provide parameter DEPTH, default 4, best-times table entries (>=2); IW = clog2(DEPTH), CW = clog2(DEPTH+1).
REQ-005 SHALL provide ports, one clock and asynchronous active-low reset:
 clk  in  1  system clock, all logic on rising edge
 reset  in  1  asynchronous, active-low reset
 start  in  1  one-cycle pulse, begin a new run
 pause  in  1  level, freeze timer while high
 gameover  in  1  one-cycle pulse, run finished
 clear_table  in  1  one-cycle pulse, empty the table
 rd_idx  in  IW  table read index
 timer  out  WIDTH  current or final run time, in ticks
 running  out  1  high in RUN state only
 rd_data  out  WIDTH  table entry at rd_idx, combinational
 best  out  WIDTH  table entry 0
 entries  out  CW  number of valid table entries
 placed  out  1  one-cycle pulse, final time entered the table
 rank  out  IW  table position of last placed time
 new_record  out  1  one-cycle pulse, placed at rank 0

Function
REQ-006 SHALL implement states IDLE, RUN, PAUSE, INSERT, DONE.
REQ-007 IDLE/DONE: start -> RUN next cycle; timer and prescaler cleared to 0 on that edge.
REQ-008 RUN: gameover -> INSERT; else pause=1 -> PAUSE; gameover has priority over pause.
REQ-009 PAUSE: gameover -> INSERT; else pause=0 -> RUN.
REQ-010 INSERT: unconditional -> DONE after exactly one cycle.
REQ-011 start SHALL be ignored in RUN, PAUSE and INSERT; gameover SHALL be ignored in IDLE, INSERT and DONE.
REQ-012 Prescaler SHALL count 0..TICK_HIT only in RUN, wrap to 0 at TICK_HIT, and hold its value in every other state.
REQ-013 Timer SHALL increment by 1 on the same edge the prescaler wraps; first increment occurs TICK_HIT+1 cycles after entering RUN.
REQ-014 Timer SHALL hold its value in PAUSE, INSERT and DONE; DONE displays the final time.
REQ-015 Table SHALL be sorted ascending (lower time is better); invalid entries read all-ones.
REQ-016 In INSERT, p = count of valid entries with value <= timer; ties keep the existing entry at the better rank.
REQ-017 If p < DEPTH: entries p..DEPTH-2 shift to p+1..DEPTH-1 and the last is discarded; entry p = timer; entries = min(entries+1, DEPTH); rank = p; placed pulses on the DONE-entry edge.
REQ-018 new_record SHALL pulse with placed only when p = 0.
REQ-019 If p = DEPTH (table full, time not better): table, entries and rank unchanged; placed and new_record stay 0.
REQ-020 clear_table SHALL act only in IDLE or DONE: all entries set to all-ones, entries = 0, rank = 0; ignored in other states.
REQ-021 clear_table and start in the same cycle SHALL both take effect.
REQ-022 best = entry 0 (all-ones when empty); rd_data = entry rd_idx, all-ones if rd_idx >= DEPTH.

Reset
REQ-023 reset low SHALL asynchronously force IDLE, prescaler 0, timer 0, running 0, placed 0, new_record 0, rank 0, entries 0, all table entries all-ones.
REQ-024 reset asserted mid-run SHALL discard the run without a table update.

Configuration
REQ-025 With SCORE_SATURATE_EN defined, timer SHALL stop at all-ones and ignore further ticks; without it, timer SHALL wrap from all-ones to 0.

Verification (CLK_FREQ=100, TICK_RATE=10, WIDTH=16, DEPTH=4)
REQ-026 start, wait 35 cycles, gameover -> timer=3, entries=1, best=3, placed=1, new_record=1, rank=0.
REQ-027 Runs of 5, 2, 7, 4 ticks -> table {2,4,5,7}; a fifth run of 9 -> placed=0, table unchanged; a run of 3 -> table {2,3,4,5}, rank=1.
REQ-028 pause high for 50 cycles mid-run -> timer and prescaler frozen; total run time excludes the paused interval exactly.
REQ-029 Tie: existing 4 plus new 4 -> new entry placed at rank 1 (after the existing 4), new_record=0.
REQ-030 WIDTH=4 run of 17 ticks -> final timer 15 with SCORE_SATURATE_EN defined, 1 without it; reset low mid-run -> all outputs at reset values, table empty.

Source files
------------

// File: rtl/score_tracker.sv
// Run timer with pause plus a sorted best-times table that absorbs each finished run.
// Build option SCORE_SATURATE_EN: timer sticks at all-ones instead of wrapping.
module score_tracker #(
  parameter int CLK_FREQ  = 100000000,
  parameter int TICK_RATE = 10,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  localparam int IW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             gameover,
  input  logic             clear_table,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] timer,
  output logic             running,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] best,
  output logic [CW-1:0]    entries,
  output logic             placed,
  output logic [IW-1:0]    rank,
  output logic             new_record
);

  localparam int TICK_HIT = CLK_FREQ / TICK_RATE - 1;
  localparam int PW = (TICK_HIT > 0) ? $clog2(TICK_HIT + 1) : 1;
  localparam logic [PW-1:0] PS_HIT = PW'(TICK_HIT);
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, INSERT, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic [WIDTH-1:0] timer_q, timer_d, timer_inc;
  logic             running_q, running_d;
  logic             placed_q, placed_d;
  logic             nr_q, nr_d;
  logic [IW-1:0]    rank_q, rank_d;
  logic [CW-1:0]    entries_q, entries_d;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [WIDTH-1:0] tbl_d [DEPTH];
  logic             tick;
  int               p;

`ifdef SCORE_SATURATE_EN
  assign timer_inc = (timer_q == ONES) ? timer_q : timer_q + 1'b1;
`else
  assign timer_inc = timer_q + 1'b1;
`endif

  // Insertion point: valid entries not worse than the new time stay ahead of it.
  always_comb begin
    p = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(entries_q) && tbl_q[i] <= timer_q) p = p + 1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    timer_d   = timer_q;
    rank_d    = rank_q;
    entries_d = entries_q;
    tbl_d     = tbl_q;
    placed_d  = 1'b0;
    nr_d      = 1'b0;
    tick      = (ps_q == PS_HIT);
    case (state_q)
      IDLE, DONE: begin
        if (clear_table) begin
          for (int i = 0; i < DEPTH; i++) tbl_d[i] = ONES;
          entries_d = '0;
          rank_d    = '0;
        end
        if (start) begin
          state_d = RUN;
          ps_d    = '0;
          timer_d = '0;
        end
      end
      RUN: begin
        ps_d = tick ? '0 : ps_q + 1'b1;
        if (tick) timer_d = timer_inc;
        if (gameover)   state_d = INSERT;
        else if (pause) state_d = PAUSE;
      end
      PAUSE: begin
        if (gameover)    state_d = INSERT;
        else if (!pause) state_d = RUN;
      end
      INSERT: begin
        state_d = DONE;
        if (p < DEPTH) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (i == p) tbl_d[i] = timer_q;
          end
          for (int i = 1; i < DEPTH; i++) begin
            if (i > p) tbl_d[i] = tbl_q[i-1];
          end
          entries_d = (entries_q == CW'(DEPTH)) ? entries_q : entries_q + 1'b1;
          rank_d    = IW'(p);
          placed_d  = 1'b1;
          nr_d      = (p == 0);
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ps_q      <= '0;
      timer_q   <= '0;
      running_q <= 1'b0;
      placed_q  <= 1'b0;
      nr_q      <= 1'b0;
      rank_q    <= '0;
      entries_q <= '0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= ONES;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      timer_q   <= timer_d;
      running_q <= running_d;
      placed_q  <= placed_d;
      nr_q      <= nr_d;
      rank_q    <= rank_d;
      entries_q <= entries_d;
      tbl_q     <= tbl_d;
    end
  end

  // Unmatched indices (only possible when DEPTH is not a power of two) read as empty.
  always_comb begin
    rd_data = ONES;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IW'(i)) rd_data = tbl_q[i];
    end
  end

  assign timer      = timer_q;
  assign running    = running_q;
  assign best       = tbl_q[0];
  assign entries    = entries_q;
  assign placed     = placed_q;
  assign rank       = rank_q;
  assign new_record = nr_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: per-cycle model comparison plus literal checkpoints.
module tb_score_tracker;
  localparam int DEPTH = 4;
  localparam int IW = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, pause = 1'b0, gameover = 1'b0, clear_table = 1'b0;
  logic [IW-1:0] rd_idx = '0;

  logic [15:0] timer, rd_data, best;
  logic running, placed, new_record;
  logic [IW-1:0] rank;
  logic [CW-1:0] entries;

  logic [3:0] timer4, rd_data4, best4;
  logic running4, placed4, nr4;
  logic [IW-1:0] rank4;
  logic [CW-1:0] entries4;

  int checks = 0;
  int failures = 0;

  score_tracker #(.CLK_FREQ(100), .TICK_RATE(10), .WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .reset(rst_n), .start(start), .pause(pause), .gameover(gameover),
    .clear_table(clear_table), .rd_idx(rd_idx), .timer(timer), .running(running),
    .rd_data(rd_data), .best(best), .entries(entries), .placed(placed), .rank(rank),
    .new_record(new_record)
  );

  score_tracker #(.CLK_FREQ(100), .TICK_RATE(10), .WIDTH(4), .DEPTH(4)) dut4 (
    .clk(clk), .reset(rst_n), .start(start), .pause(pause), .gameover(gameover),
    .clear_table(clear_table), .rd_idx(rd_idx), .timer(timer4), .running(running4),
    .rd_data(rd_data4), .best(best4), .entries(entries4), .placed(placed4), .rank(rank4),
    .new_record(nr4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: elapsed RUN cycles give the time; the table is a sorted queue.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_INSERT, M_DONE} mstate_t;
  mstate_t ms = M_IDLE;
  int mcyc = 0;
  int mtbl[$];
  int m_rank = 0;
  bit m_placed = 0, m_nr = 0;
  int mt, mp;

  function automatic int exp_timer();
    return (mcyc / 10) % 65536;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms = M_IDLE; mcyc = 0; mtbl.delete(); m_rank = 0; m_placed = 0; m_nr = 0;
    end else begin
      m_placed = 0;
      m_nr = 0;
      case (ms)
        M_IDLE, M_DONE: begin
          if (clear_table) begin mtbl.delete(); m_rank = 0; end
          if (start) begin ms = M_RUN; mcyc = 0; end
        end
        M_RUN: begin
          mcyc++;
          if (gameover) ms = M_INSERT;
          else if (pause) ms = M_PAUSE;
        end
        M_PAUSE: begin
          if (gameover) ms = M_INSERT;
          else if (!pause) ms = M_RUN;
        end
        M_INSERT: begin
          mt = exp_timer();
          mp = 0;
          foreach (mtbl[i]) if (mtbl[i] <= mt) mp++;
          if (mp < DEPTH) begin
            mtbl.insert(mp, mt);
            if (mtbl.size() > DEPTH) void'(mtbl.pop_back());
            m_rank = mp; m_placed = 1; m_nr = (mp == 0);
          end
          ms = M_DONE;
        end
        default: ms = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("timer", timer, exp_timer());
      chk("running", running, ms == M_RUN);
      chk("entries", entries, mtbl.size());
      chk("best", best, (mtbl.size() > 0) ? mtbl[0] : 32'hFFFF);
      chk("rd_data", rd_data, (int'(rd_idx) < mtbl.size()) ? mtbl[rd_idx] : 32'hFFFF);
      chk("placed", placed, m_placed);
      chk("new_record", new_record, m_nr);
      chk("rank", rank, m_rank);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd_idx = rd_idx + 1'b1;
  endtask

  // Gameover lands mid-tick-period so the final time is exactly n.
  task automatic run(input int n);
    start = 1'b1; tick(); start = 1'b0;
    repeat (10 * n + 4) tick();
    gameover = 1'b1; tick(); gameover = 1'b0;
    tick();
  endtask

  task automatic clr();
    clear_table = 1'b1; tick(); clear_table = 1'b0;
  endtask

  task automatic read_tbl(input int e[4]);
    for (int i = 0; i < 4; i++) begin
      rd_idx = IW'(i);
      #1;
      chk("table_entry", rd_data, e[i]);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_timer", timer, 0);
    chk("rst_running", running, 0);
    chk("rst_entries", entries, 0);
    chk("rst_best", best, 16'hFFFF);
    chk("rst_placed", placed, 0);
    rst_n = 1'b1;
    tick();

    run(3);
    chk("r3_timer", timer, 3);
    chk("r3_entries", entries, 1);
    chk("r3_best", best, 3);
    chk("r3_placed", placed, 1);
    chk("r3_new_record", new_record, 1);
    chk("r3_rank", rank, 0);
    tick();
    chk("placed_one_cycle", placed, 0);
    clr();
    chk("clear_entries", entries, 0);
    chk("clear_best", best, 16'hFFFF);

    run(5); run(2); run(7); run(4);
    read_tbl('{2, 4, 5, 7});
    run(9);
    chk("slow_placed", placed, 0);
    chk("slow_new_record", new_record, 0);
    chk("slow_entries", entries, 4);
    read_tbl('{2, 4, 5, 7});
    run(3);
    chk("r3b_rank", rank, 1);
    chk("r3b_placed", placed, 1);
    read_tbl('{2, 3, 4, 5});

    clr();
    run(4); run(4);
    chk("tie_rank", rank, 1);
    chk("tie_new_record", new_record, 0);
    chk("tie_entries", entries, 2);

    // 25 RUN cycles, 50 cycles paused, then 40 more RUN cycles: 65 cycles -> 6 ticks.
    start = 1'b1; tick(); start = 1'b0;
    repeat (24) tick();
    pause = 1'b1;
    repeat (25) tick();
    chk("pause_frozen_timer", timer, 2);
    clr();
    repeat (24) tick();
    pause = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (38) tick();
    gameover = 1'b1; tick(); gameover = 1'b0;
    tick();
    chk("pause_timer", timer, 6);
    chk("pause_rank", rank, 2);
    chk("pause_entries", entries, 3);
    gameover = 1'b1; tick(); gameover = 1'b0;
    chk("done_ignores_gameover", running, 0);

    run(17);
    chk("w16_timer17", timer, 17);
`ifdef SCORE_SATURATE_EN
    chk("w4_timer17", timer4, 15);
`else
    chk("w4_timer17", timer4, 1);
`endif

    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_timer", timer, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_entries", entries, 0);
    chk("mid_rst_best", best, 16'hFFFF);
    chk("mid_rst_rank", rank, 0);
    chk("mid_rst_w4_timer", timer4, 0);
    chk("mid_rst_w4_entries", entries4, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_entries", entries, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
